// File: rtl/definitions_pkg.sv
// Shared types and encodings for the multi-cycle MIPS datapath and its control unit.
// The ALU operation type is consumed unchanged by the existing ALU.
package definitions_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_LU
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPE_EX, S_RTYPE_WB, S_IMM_EX, S_IMM_WB, S_BRANCH, S_JUMP
    } ctrl_state_t;

    // How the ALU operation is chosen in the current state.
    typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_RTYPE, CLS_IMM} alu_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REGA  = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_en;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zero_ext;
        alu_op_t    alu_op;
        logic       illegal;
    } ctrl_out_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Maps opcode/funct and the state's ALU class to an ALU operation, the shamt
// operand select for shifts, and an unknown-funct flag.
module alu_op_decoder
    import definitions_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  alu_class_t i_class,
    output alu_op_t    o_alu_op,
    output logic       o_shift_sel,
    output logic       o_funct_illegal
);

    always_comb begin
        o_alu_op        = ALU_ADD;
        o_shift_sel     = 1'b0;
        o_funct_illegal = 1'b0;
        case (i_class)
            CLS_SUB: o_alu_op = ALU_SUB;
            CLS_RTYPE: begin
                case (i_funct)
                    FN_ADD: o_alu_op = ALU_ADD;
                    FN_SUB: o_alu_op = ALU_SUB;
                    FN_AND: o_alu_op = ALU_AND;
                    FN_OR:  o_alu_op = ALU_OR;
                    FN_XOR: o_alu_op = ALU_XOR;
                    FN_SLL: begin o_alu_op = ALU_SLL; o_shift_sel = 1'b1; end
                    FN_SRL: begin o_alu_op = ALU_SRL; o_shift_sel = 1'b1; end
                    FN_SRA: begin o_alu_op = ALU_SRA; o_shift_sel = 1'b1; end
                    default: o_funct_illegal = 1'b1;
                endcase
            end
            CLS_IMM: begin
                case (i_opcode)
                    OP_ANDI: o_alu_op = ALU_AND;
                    OP_ORI:  o_alu_op = ALU_OR;
                    OP_XORI: o_alu_op = ALU_XOR;
                    OP_LUI:  o_alu_op = ALU_LU;
                    default: o_alu_op = ALU_ADD;
                endcase
            end
            default: o_alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback and
// drives the datapath selects, the ALU operation and the shared memory port.
module mips_multicycle_control
    import definitions_pkg::*;
#(
    parameter int unsigned WAIT_MEM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        equal,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_en,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        imm_zero_ext,
    output alu_op_t     alu_op,
    output logic        illegal,
    output ctrl_state_t dbg_state
);

    ctrl_state_t r_state;
    ctrl_state_t w_next;
    alu_class_t  w_class;
    alu_op_t     w_alu_op;
    logic        w_shift_sel;
    logic        w_funct_illegal;
    logic        w_ready;
    ctrl_out_t   w_ctl;
    ctrl_out_t   w_out;

    assign w_ready = (WAIT_MEM == 0) ? 1'b1 : mem_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        case (r_state)
            S_RTYPE_EX: w_class = CLS_RTYPE;
            S_IMM_EX:   w_class = CLS_IMM;
            S_BRANCH:   w_class = CLS_SUB;
            default:    w_class = CLS_ADD;
        endcase
    end

    alu_op_decoder u_alu_op_decoder (
        .i_opcode        (opcode),
        .i_funct         (funct),
        .i_class         (w_class),
        .o_alu_op        (w_alu_op),
        .o_shift_sel     (w_shift_sel),
        .o_funct_illegal (w_funct_illegal)
    );

    always_comb begin
        w_ctl        = '0;
        w_ctl.alu_op = w_alu_op;
        w_next       = r_state;
        case (r_state)
            S_FETCH: begin
                w_ctl.mem_req   = 1'b1;
                w_ctl.alu_src_b = SRCB_FOUR;
                if (w_ready) begin
                    w_ctl.ir_en = 1'b1;
                    w_ctl.pc_en = 1'b1;
                    w_next      = S_DECODE;
                end
            end
            S_DECODE: begin
                w_ctl.alu_src_b = SRCB_BRANCH;
                case (opcode)
                    OP_LW, OP_SW:                            w_next = S_MEMADR;
                    OP_RTYPE:                                w_next = S_RTYPE_EX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_next = S_IMM_EX;
                    OP_BEQ, OP_BNE:                          w_next = S_BRANCH;
                    OP_J:                                    w_next = S_JUMP;
                    default: begin
                        w_ctl.illegal = 1'b1;
                        w_next        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_ctl.alu_src_a = SRCA_REGA;
                w_ctl.alu_src_b = SRCB_IMM;
                w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_ctl.mem_req = 1'b1;
                w_ctl.iord    = 1'b1;
                if (w_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_ctl.reg_we     = 1'b1;
                w_ctl.mem_to_reg = 1'b1;
                w_next           = S_FETCH;
            end
            S_MEMWR: begin
                w_ctl.mem_req = 1'b1;
                w_ctl.mem_we  = 1'b1;
                w_ctl.iord    = 1'b1;
                if (w_ready) w_next = S_FETCH;
            end
            S_RTYPE_EX: begin
                // An unknown funct only raises illegal; nothing else is driven.
                if (w_funct_illegal) begin
                    w_ctl.illegal = 1'b1;
                    w_next        = S_FETCH;
                end else begin
                    w_ctl.alu_src_a = w_shift_sel ? SRCA_SHAMT : SRCA_REGA;
                    w_ctl.alu_src_b = SRCB_REGB;
                    w_next          = S_RTYPE_WB;
                end
            end
            S_RTYPE_WB: begin
                w_ctl.reg_we  = 1'b1;
                w_ctl.reg_dst = 1'b1;
                w_next        = S_FETCH;
            end
            S_IMM_EX: begin
                w_ctl.alu_src_a    = SRCA_REGA;
                w_ctl.alu_src_b    = SRCB_IMM;
                w_ctl.imm_zero_ext = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
                w_next             = S_IMM_WB;
            end
            S_IMM_WB: begin
                w_ctl.reg_we = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_ctl.alu_src_a = SRCA_REGA;
                w_ctl.alu_src_b = SRCB_REGB;
                w_ctl.pc_src    = PC_SRC_ALUOUT;
                w_ctl.pc_en     = ((opcode == OP_BEQ) && equal) || ((opcode == OP_BNE) && !equal);
                w_next          = S_FETCH;
            end
            S_JUMP: begin
                w_ctl.pc_src = PC_SRC_JUMP;
                w_ctl.pc_en  = 1'b1;
                w_next       = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset silences every output, including the combinational FETCH/BRANCH gating.
    assign w_out = rst ? '0 : w_ctl;

    assign mem_req      = w_out.mem_req;
    assign mem_we       = w_out.mem_we;
    assign iord         = w_out.iord;
    assign ir_en        = w_out.ir_en;
    assign pc_en        = w_out.pc_en;
    assign pc_src       = w_out.pc_src;
    assign reg_we       = w_out.reg_we;
    assign reg_dst      = w_out.reg_dst;
    assign mem_to_reg   = w_out.mem_to_reg;
    assign alu_src_a    = w_out.alu_src_a;
    assign alu_src_b    = w_out.alu_src_b;
    assign imm_zero_ext = w_out.imm_zero_ext;
    assign alu_op       = w_out.alu_op;
    assign illegal      = w_out.illegal;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multi-cycle control unit: per-cycle expected state and
// control words are queued by hand for each instruction and compared in order.
module tb_mips_multicycle_control;
    import definitions_pkg::*;

    localparam int W = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        equal;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_en, pc_en;
    logic [1:0]  pc_src;
    logic        reg_we, reg_dst, mem_to_reg;
    logic [1:0]  alu_src_a, alu_src_b;
    logic        imm_zero_ext;
    alu_op_t     alu_op;
    logic        illegal;
    ctrl_state_t dbg_state;

    logic [W-1:0] exp_q[$];
    logic [1:0]   in_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.WAIT_MEM(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .equal(equal),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_zero_ext(imm_zero_ext), .alu_op(alu_op),
        .illegal(illegal), .dbg_state(dbg_state)
    );

    function automatic logic [15:0] cv(input logic mreq, mwe, io, ire, pce,
                                       input logic [1:0] pcs,
                                       input logic rwe, rdst, m2r,
                                       input logic [1:0] sa, sb,
                                       input logic zx, ill);
        return {mreq, mwe, io, ire, pce, pcs, rwe, rdst, m2r, sa, sb, zx, ill};
    endfunction

    function automatic logic [W-1:0] ev(input ctrl_state_t st, input alu_op_t op, input logic [15:0] c);
        return {st, op, c};
    endfunction

    function automatic logic [W-1:0] obs();
        return {dbg_state, alu_op, mem_req, mem_we, iord, ir_en, pc_en, pc_src,
                reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zero_ext, illegal};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] e_v);
        n_tests++;
        if (got !== e_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, e_v);
        end
    endtask

    task automatic push(input logic r, input logic rdy, input logic [W-1:0] v);
        in_q.push_back({r, rdy});
        exp_q.push_back(v);
    endtask

    task automatic push_fetch(input logic rdy);
        push(1'b0, rdy, ev(S_FETCH, ALU_ADD, cv(1,0,0,rdy,rdy,2'b00,0,0,0,2'b00,2'b01,0,0)));
    endtask

    task automatic push_decode(input logic ill);
        push(1'b0, 1'b1, ev(S_DECODE, ALU_ADD, cv(0,0,0,0,0,2'b00,0,0,0,2'b00,2'b11,0,ill)));
    endtask

    // Each queued cycle: apply inputs, let outputs settle, compare, then advance one edge.
    task automatic run(input string tag);
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            logic [1:0]   iv;
            logic [W-1:0] e_v;
            iv  = in_q.pop_front();
            e_v = exp_q.pop_front();
            rst       = iv[1];
            mem_ready = iv[0];
            #1;
            chk($sformatf("%s[%0d]", tag, cyc), obs(), e_v);
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] br_pce;
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h00; equal = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push(1'b1, 1'b1, ev(S_FETCH, ALU_ADD, 16'h0000));
        run("reset");

        opcode = 6'h00; funct = 6'h22;
        push_fetch(1); push_decode(0);
        push(0, 1, ev(S_RTYPE_EX, ALU_SUB, cv(0,0,0,0,0,2'b00,0,0,0,2'b01,2'b00,0,0)));
        push(0, 1, ev(S_RTYPE_WB, ALU_ADD, cv(0,0,0,0,0,2'b00,1,1,0,2'b00,2'b00,0,0)));
        run("sub");

        funct = 6'h03;
        push_fetch(1); push_decode(0);
        push(0, 1, ev(S_RTYPE_EX, ALU_SRA, cv(0,0,0,0,0,2'b00,0,0,0,2'b10,2'b00,0,0)));
        push(0, 1, ev(S_RTYPE_WB, ALU_ADD, cv(0,0,0,0,0,2'b00,1,1,0,2'b00,2'b00,0,0)));
        run("sra");

        opcode = 6'h23;
        push_fetch(1); push_decode(0);
        push(0, 1, ev(S_MEMADR, ALU_ADD, cv(0,0,0,0,0,2'b00,0,0,0,2'b01,2'b10,0,0)));
        push(0, 0, ev(S_MEMRD,  ALU_ADD, cv(1,0,1,0,0,2'b00,0,0,0,2'b00,2'b00,0,0)));
        push(0, 0, ev(S_MEMRD,  ALU_ADD, cv(1,0,1,0,0,2'b00,0,0,0,2'b00,2'b00,0,0)));
        push(0, 1, ev(S_MEMRD,  ALU_ADD, cv(1,0,1,0,0,2'b00,0,0,0,2'b00,2'b00,0,0)));
        push(0, 1, ev(S_MEMWB,  ALU_ADD, cv(0,0,0,0,0,2'b00,1,0,1,2'b00,2'b00,0,0)));
        run("lw_stall");

        opcode = 6'h2B;
        push_fetch(0); push_fetch(1); push_decode(0);
        push(0, 1, ev(S_MEMADR, ALU_ADD, cv(0,0,0,0,0,2'b00,0,0,0,2'b01,2'b10,0,0)));
        push(0, 1, ev(S_MEMWR,  ALU_ADD, cv(1,1,1,0,0,2'b00,0,0,0,2'b00,2'b00,0,0)));
        run("sw_fetch_stall");

        // beq eq=1, beq eq=0, bne eq=1, bne eq=0 -> taken, not, not, taken
        br_pce = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            opcode = (k < 2) ? 6'h04 : 6'h05;
            equal  = (k == 0) || (k == 2);
            push_fetch(1); push_decode(0);
            push(0, 1, ev(S_BRANCH, ALU_SUB, cv(0,0,0,0,br_pce[k],2'b01,0,0,0,2'b01,2'b00,0,0)));
            run($sformatf("branch%0d", k));
        end
        equal = 1'b0;

        opcode = 6'h02;
        push_fetch(1); push_decode(0);
        push(0, 1, ev(S_JUMP, ALU_ADD, cv(0,0,0,0,1,2'b10,0,0,0,2'b00,2'b00,0,0)));
        run("jump");

        opcode = 6'h3F;
        push_fetch(1); push_decode(1);
        run("bad_opcode");

        opcode = 6'h0D;
        push_fetch(1); push_decode(0);
        push(0, 1, ev(S_IMM_EX, ALU_OR,  cv(0,0,0,0,0,2'b00,0,0,0,2'b01,2'b10,1,0)));
        push(0, 1, ev(S_IMM_WB, ALU_ADD, cv(0,0,0,0,0,2'b00,1,0,0,2'b00,2'b00,0,0)));
        run("ori");

        opcode = 6'h0F;
        push_fetch(1); push_decode(0);
        push(0, 1, ev(S_IMM_EX, ALU_LU,  cv(0,0,0,0,0,2'b00,0,0,0,2'b01,2'b10,0,0)));
        push(0, 1, ev(S_IMM_WB, ALU_ADD, cv(0,0,0,0,0,2'b00,1,0,0,2'b00,2'b00,0,0)));
        run("lui");

        opcode = 6'h00; funct = 6'h3F;
        push_fetch(1); push_decode(0);
        push(0, 1, ev(S_RTYPE_EX, ALU_ADD, cv(0,0,0,0,0,2'b00,0,0,0,2'b00,2'b00,0,1)));
        run("bad_funct");

        opcode = 6'h2B;
        push_fetch(1); push_decode(0);
        push(0, 1, ev(S_MEMADR, ALU_ADD, cv(0,0,0,0,0,2'b00,0,0,0,2'b01,2'b10,0,0)));
        push(0, 0, ev(S_MEMWR,  ALU_ADD, cv(1,1,1,0,0,2'b00,0,0,0,2'b00,2'b00,0,0)));
        push(1, 0, ev(S_MEMWR,  ALU_ADD, 16'h0000));
        push_fetch(1); push_decode(0);
        push(0, 1, ev(S_MEMADR, ALU_ADD, cv(0,0,0,0,0,2'b00,0,0,0,2'b01,2'b10,0,0)));
        push(0, 1, ev(S_MEMWR,  ALU_ADD, cv(1,1,1,0,0,2'b00,0,0,0,2'b00,2'b00,0,0)));
        run("rst_in_memwr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
